// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit a+b+cin cut into STAGES carry-pipelined slices; PIPELINED_ADDER_SUB_EN adds a sub port (a-b).
// Latency STAGES cycles at one add per cycle; a held output (out_ready low) freezes every stage and drops in_ready.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Needs STAGES >= 2 and WIDTH % STAGES == 0.
  localparam int SW = WIDTH / STAGES;
  // Total width of the shrinking B-operand skew registers between stages.
  localparam int BT = (STAGES - 1) * WIDTH - SW * (STAGES - 1) * STAGES / 2;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [BT-1:0]     brem_q, brem_d;
  logic              ovf_q, ovf_d;

  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic ci);
    logic          c;
    logic [SW:0]   r;
    c = ci;
    r = '0;
    for (int i = 0; i < SW; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[SW] = c;
    return r;
  endfunction

`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff = b ^ {WIDTH{sub}};
  assign c0    = sub | cin;
`else
  assign b_eff = b;
  assign c0    = cin;
`endif

  assign adv       = ~(out_valid & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ovf_q;

  // acc shifts right one slice per stage: pending A slices drain from the bottom while
  // finished sum slices enter at the top, so the last stage holds the whole aligned sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RB = WIDTH - (k + 1) * SW;
    logic [WIDTH-1:0]   xa;
    logic [RB+SW-1:0]   xb;
    logic               ci;
    logic [SW:0]        r;

    if (k == 0) begin : g_src
      assign xa = a;
      assign xb = b_eff;
      assign ci = c0;
    end else begin : g_src
      localparam int OFFP = (k - 1) * WIDTH - SW * (k - 1) * k / 2;
      assign xa = acc_q[k-1];
      assign xb = brem_q[OFFP +: RB + SW];
      assign ci = cy_q[k-1];
    end

    assign r        = slice_add(xa[SW-1:0], xb[SW-1:0], ci);
    assign acc_d[k] = {r[SW-1:0], xa[WIDTH-1:SW]};
    assign cy_d[k]  = r[SW];

    if (k < STAGES - 1) begin : g_fwd
      localparam int OFF = k * WIDTH - SW * k * (k + 1) / 2;
      assign brem_d[OFF +: RB] = xb[RB+SW-1:SW];
    end else begin : g_last
      assign ovf_d = (xa[SW-1] == xb[SW-1]) & (r[SW-1] != xa[SW-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      brem_q <= '0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) acc_q[k] <= '0;
    end else if (adv) begin
      vld_q  <= {vld_q[STAGES-2:0], in_valid};
      cy_q   <= cy_d;
      brem_q <= brem_d;
      ovf_q  <= ovf_d;
      for (int k = 0; k < STAGES; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4); covers the sub port when PIPELINED_ADDER_SUB_EN is defined.
module tb_pipelined_adder;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin       = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
`ifdef PIPELINED_ADDER_SUB_EN
  logic         sub       = 1'b0;
`endif
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hABCD, 16'h0000, 16'h7FFF, 16'hDEAD};
  logic [15:0] vb [8] = '{16'h4321, 16'hFFFF, 16'h7FFF, 16'hF0F1, 16'h5432, 16'h0000, 16'h7FFF, 16'hBEEF};
  logic        vc [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
    logic [15:0] yb;
    logic [16:0] t;
    logic        v;
    yb = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yb} + {16'd0, (s | c)};
    v  = (x[15] == yb[15]) && (t[15] != x[15]);
    return {v, t};
  endfunction

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic c, input logic v);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = v;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_wrap();
    @(negedge clk); drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_early: out_valid got %b expected 0 at T+3", out_valid); end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
      n_err++; $display("FAIL wrap_result: got v=%b c=%b o=%b s=%h expected v=1 c=1 o=0 s=0000", out_valid, cout, ovf, sum);
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_dup: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_carry_chain();
    @(negedge clk); drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    @(negedge clk); drive(16'h00FF, 16'h0F01, 1'b1, 1'b1);
    @(negedge clk); drive(16'h8000, 16'h8000, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b0, 1'b1, 16'h8000}) begin
      n_err++; $display("FAIL carry_pos_ovf: got v=%b c=%b o=%b s=%h expected v=1 c=0 o=1 s=8000", out_valid, cout, ovf, sum);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 16'h1001}) begin
      n_err++; $display("FAIL carry_slices: got v=%b c=%b o=%b s=%h expected v=1 c=0 o=0 s=1001", out_valid, cout, ovf, sum);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b1, 1'b1, 16'h0000}) begin
      n_err++; $display("FAIL carry_neg_ovf: got v=%b c=%b o=%b s=%h expected v=1 c=1 o=1 s=0000", out_valid, cout, ovf, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c >= 4 && c < 12) begin
        e = ref_add(va[c-4], vb[c-4], vc[c-4], 1'b0);
        n_cmp++;
        if ({out_valid, ovf, cout, sum} !== {1'b1, e}) begin
          n_err++; $display("FAIL b2b_item%0d: got v=%b {o,c,s}=%h expected v=1 {o,c,s}=%h", c - 4, out_valid, {ovf, cout, sum}, e);
        end
      end
      if (c == 12) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail: out_valid got %b expected 0", out_valid); end
      end
      if (c < 8) drive(va[c], vb[c], vc[c], 1'b1);
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] e;
    int got;
    got = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        e = ref_add(va[0], vb[0], vc[0], 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready); end
        n_cmp++;
        if ({out_valid, ovf, cout, sum} !== {1'b1, e}) begin
          n_err++; $display("FAIL bp_hold c%0d: got v=%b {o,c,s}=%h expected v=1 {o,c,s}=%h", c, out_valid, {ovf, cout, sum}, e);
        end
      end
      if (c < 4) drive(va[c], vb[c], vc[c], 1'b1);
      else if (c <= 7) drive(va[4], vb[4], vc[4], 1'b1);
      else in_valid = 1'b0;
      out_ready = (c >= 7);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (got >= 5) begin
          n_err++; $display("FAIL bp_extra: got delivery %0d expected at most 5", got + 1);
        end else begin
          e = ref_add(va[got], vb[got], vc[got], 1'b0);
          if ({ovf, cout, sum} !== e) begin
            n_err++; $display("FAIL bp_order%0d: got {o,c,s}=%h expected %h", got, {ovf, cout, sum}, e);
          end
        end
        got++;
      end
    end
    n_cmp++; if (got !== 5) begin n_err++; $display("FAIL bp_count: got %0d deliveries expected 5", got); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    out_ready = 1'b1;
    @(negedge clk); drive(16'h1111, 16'h2222, 1'b0, 1'b1);
    @(negedge clk); drive(16'h3333, 16'h4444, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: out_valid got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_async: out_valid got %b expected 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_stale: got %0d valid cycles expected 0", seen); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
  endtask

`ifdef PIPELINED_ADDER_SUB_EN
  task automatic test_sub();
    @(negedge clk); drive(16'h0003, 16'h0005, 1'b0, 1'b1); sub = 1'b1;
    @(negedge clk); drive(16'h8000, 16'h0001, 1'b1, 1'b1); sub = 1'b1;
    @(negedge clk); in_valid = 1'b0; sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 16'hFFFE}) begin
      n_err++; $display("FAIL sub_borrow: got v=%b c=%b o=%b s=%h expected v=1 c=0 o=0 s=FFFE", out_valid, cout, ovf, sum);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b1, 1'b1, 16'h7FFF}) begin
      n_err++; $display("FAIL sub_ovf: got v=%b c=%b o=%b s=%h expected v=1 c=1 o=1 s=7FFF", out_valid, cout, ovf, sum);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_wrap();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef PIPELINED_ADDER_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
